// File: rtl/adc_sample_averager.sv
// Block (boxcar-and-dump) averager: sums 2**LOG2_N strobed ADC samples and emits
// their truncated mean with a one-cycle valid pulse. Define MINMAX_EN for block min/max outputs.
module adc_sample_averager #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_stb,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic [LOG2_N-1:0] sample_idx
`ifdef MINMAX_EN
  ,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out
`endif
);

  localparam int ACC_W = DATA_W + LOG2_N;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [LOG2_N-1:0]   r_idx;
  logic [DATA_W-1:0]   r_avg;
  logic                r_valid;

  logic [ACC_W-1:0]    w_sum;
  logic                w_last;
  logic                w_take;
  logic                w_done;

  assign w_sum  = r_acc + ACC_W'(sample_in);
  assign w_last = &r_idx;
  // en low overrides everything, so a strobe coincident with en falling is dropped.
  assign w_take = en && (r_state == S_ACCUM) && sample_stb;
  assign w_done = w_take && w_last;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_idx   <= '0;
      r_avg   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!en) begin
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_idx   <= '0;
      end else begin
        case (r_state)
          S_IDLE:  r_state <= S_ACCUM;
          S_ACCUM: begin
            if (w_done) begin
              r_avg   <= w_sum[ACC_W-1:LOG2_N];
              r_valid <= 1'b1;
              r_acc   <= '0;
              r_idx   <= '0;
            end else if (w_take) begin
              r_acc <= w_sum;
              r_idx <= r_idx + LOG2_N'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign avg_out    = r_avg;
  assign avg_valid  = r_valid;
  assign sample_idx = r_idx;

`ifdef MINMAX_EN
  logic [DATA_W-1:0] r_min, r_max, r_min_out, r_max_out;
  logic [DATA_W-1:0] w_min_nxt, w_max_nxt;

  assign w_min_nxt = (sample_in < r_min) ? sample_in : r_min;
  assign w_max_nxt = (sample_in > r_max) ? sample_in : r_max;

  // Running extremes re-arm to all-ones / zero whenever a block starts or is discarded.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_min     <= '1;
      r_max     <= '0;
      r_min_out <= '0;
      r_max_out <= '0;
    end else if (!en) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_done) begin
      r_min_out <= w_min_nxt;
      r_max_out <= w_max_nxt;
      r_min     <= '1;
      r_max     <= '0;
    end else if (w_take) begin
      r_min <= w_min_nxt;
      r_max <= w_max_nxt;
    end
  end

  assign min_out = r_min_out;
  assign max_out = r_max_out;
`endif

endmodule
